// File: rtl/reg_file_sb.sv
// reg_file_sb: 8-entry register file with one-hot writeback/issue scoreboard and sticky select-error flag.
// Define RF_BYPASS_EN to forward same-cycle writeback data into the registered read ports.
module reg_file_sb #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_onehot,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_valid,
  input  logic [7:0]       iss_onehot,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [7:0]       busy,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic             onehot_err
);
  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_legal, iss_legal, bad_sel;
  logic [7:0]       clr, set;
  logic [WIDTH-1:0] next_a, next_b;
  always_comb begin
    wr_legal  = $onehot(wr_onehot);
    iss_legal = $onehot(iss_onehot);
    bad_sel   = (wr_en & ~wr_legal) | (iss_valid & ~iss_legal);
    clr       = (wr_en & wr_legal) ? wr_onehot : 8'h00;
    set       = (iss_valid & iss_legal) ? iss_onehot : 8'h00;
    hazard_a  = busy[rd_addr_a] & ~clr[rd_addr_a];
    hazard_b  = busy[rd_addr_b] & ~clr[rd_addr_b];
`ifdef RF_BYPASS_EN
    next_a    = clr[rd_addr_a] ? wr_data : regs[rd_addr_a];
    next_b    = clr[rd_addr_b] ? wr_data : regs[rd_addr_b];
`else
    next_a    = regs[rd_addr_a];
    next_b    = regs[rd_addr_b];
`endif
  end
  // set is applied after clear so a same-cycle issue keeps the register busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
      busy       <= '0;
      onehot_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) if (clr[i]) regs[i] <= wr_data;
      rd_data_a  <= next_a;
      rd_data_b  <= next_b;
      busy       <= (busy & ~clr) | set;
      onehot_err <= onehot_err | bad_sel;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector table, reset sequences and randomized checking against a reference model.
module tb_reg_file_sb;
  logic        clk = 0, rst = 1;
  logic        wr_en = 0, iss_valid = 0;
  logic [7:0]  wr_onehot = 0, iss_onehot = 0;
  logic [15:0] wr_data = 0;
  logic [2:0]  rd_addr_a = 0, rd_addr_b = 0;
  logic [15:0] rd_data_a, rd_data_b;
  logic [7:0]  busy;
  logic        hazard_a, hazard_b, onehot_err;
  int          errors = 0, checks = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file_sb #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_onehot(wr_onehot), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_onehot(iss_onehot), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .busy(busy), .hazard_a(hazard_a),
    .hazard_b(hazard_b), .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  woh;
    logic [15:0] wd;
    logic        iv;
    logic [7:0]  ioh;
    logic [2:0]  ra, rb;
    logic [15:0] rda, rdb;
    logic [7:0]  bsy;
    logic        err, ha, hb;
  } vec_t;
  vec_t tbl [15];

  // reference model state
  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;
  logic        m_err;
  logic [15:0] m_rda, m_rdb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic we, input logic [7:0] woh, input logic [15:0] wd,
                        input logic iv, input logic [7:0] ioh, input logic [2:0] ra, input logic [2:0] rb);
    wr_en = we; wr_onehot = woh; wr_data = wd; iss_valid = iv; iss_onehot = ioh;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = '0; m_err = 0; m_rda = '0; m_rdb = '0;
  endtask

  function automatic int sel_idx(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic step_vec(input vec_t v, input int n);
    @(negedge clk);
    set_in(v.we, v.woh, v.wd, v.iv, v.ioh, v.ra, v.rb);
    #1;
    chk($sformatf("v%0d hazard_a", n), hazard_a, v.ha);
    chk($sformatf("v%0d hazard_b", n), hazard_b, v.hb);
    @(posedge clk); #1;
    chk($sformatf("v%0d rd_data_a", n), rd_data_a, v.rda);
    chk($sformatf("v%0d rd_data_b", n), rd_data_b, v.rdb);
    chk($sformatf("v%0d busy", n), busy, v.bsy);
    chk($sformatf("v%0d onehot_err", n), onehot_err, v.err);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    set_in(1, 8'h01, 16'hFFFF, 1, 8'h80, 3'd0, 3'd7);
    #2 rst = 1;
    #1;
    chk({tag, " async rd_data_a"}, rd_data_a, 0);
    chk({tag, " async rd_data_b"}, rd_data_b, 0);
    chk({tag, " async busy"}, busy, 0);
    chk({tag, " async onehot_err"}, onehot_err, 0);
    chk({tag, " async hazard_a"}, hazard_a, 0);
    chk({tag, " async hazard_b"}, hazard_b, 0);
    @(posedge clk); #1;
    chk({tag, " held busy"}, busy, 0);
    chk({tag, " held rd_data_a"}, rd_data_a, 0);
    @(negedge clk);
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_clear();
  endtask

  task automatic rand_step(input int n);
    logic we, iv, wl, il;
    logic [7:0] woh, ioh;
    logic [15:0] wd;
    logic [2:0] ra, rb;
    logic exp_ha, exp_hb;
    we  = $urandom_range(0, 1);
    iv  = $urandom_range(0, 1);
    woh = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
    ioh = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
    wd  = 16'($urandom);
    ra  = 3'($urandom); rb = 3'($urandom);
    wl  = we && $countones(woh) == 1;
    il  = iv && $countones(ioh) == 1;
    exp_ha = m_busy[ra] && !(wl && woh[ra]);
    exp_hb = m_busy[rb] && !(wl && woh[rb]);
    m_rda = (BYP && wl && woh[ra]) ? wd : m_regs[ra];
    m_rdb = (BYP && wl && woh[rb]) ? wd : m_regs[rb];
    if (wl) begin
      m_regs[sel_idx(woh)] = wd;
      m_busy[sel_idx(woh)] = 1'b0;
    end
    if (il) m_busy[sel_idx(ioh)] = 1'b1;
    if ((we && !wl) || (iv && !il)) m_err = 1'b1;
    @(negedge clk);
    set_in(we, woh, wd, iv, ioh, ra, rb);
    #1;
    chk($sformatf("r%0d hazard_a", n), hazard_a, exp_ha);
    chk($sformatf("r%0d hazard_b", n), hazard_b, exp_hb);
    @(posedge clk); #1;
    chk($sformatf("r%0d rd_data_a", n), rd_data_a, m_rda);
    chk($sformatf("r%0d rd_data_b", n), rd_data_b, m_rdb);
    chk($sformatf("r%0d busy", n), busy, m_busy);
    chk($sformatf("r%0d onehot_err", n), onehot_err, m_err);
  endtask

  initial begin
    //             we woh    wd        iv ioh    ra rb  rda                        rdb                        busy   err ha hb
    tbl[0]  = '{0, 8'h00, 16'h0000, 0, 8'h00, 0, 7, 16'h0000,                  16'h0000,                  8'h00, 0, 0, 0};
    tbl[1]  = '{1, 8'h08, 16'hBEEF, 0, 8'h00, 1, 2, 16'h0000,                  16'h0000,                  8'h00, 0, 0, 0};
    tbl[2]  = '{0, 8'h00, 16'h0000, 0, 8'h00, 3, 3, 16'hBEEF,                  16'hBEEF,                  8'h00, 0, 0, 0};
    tbl[3]  = '{0, 8'h00, 16'h0000, 1, 8'h04, 3, 2, 16'hBEEF,                  16'h0000,                  8'h04, 0, 0, 0};
    tbl[4]  = '{0, 8'h00, 16'h0000, 0, 8'h00, 3, 2, 16'hBEEF,                  16'h0000,                  8'h04, 0, 0, 1};
    tbl[5]  = '{1, 8'h04, 16'h0C0C, 0, 8'h00, 3, 2, 16'hBEEF,                  BYP ? 16'h0C0C : 16'h0000, 8'h00, 0, 0, 0};
    tbl[6]  = '{0, 8'h00, 16'h0000, 0, 8'h00, 3, 2, 16'hBEEF,                  16'h0C0C,                  8'h00, 0, 0, 0};
    tbl[7]  = '{1, 8'h02, 16'h1234, 1, 8'h02, 1, 2, BYP ? 16'h1234 : 16'h0000, 16'h0C0C,                  8'h02, 0, 0, 0};
    tbl[8]  = '{0, 8'h00, 16'h0000, 0, 8'h00, 1, 2, 16'h1234,                  16'h0C0C,                  8'h02, 0, 1, 0};
    tbl[9]  = '{1, 8'h20, 16'hA5A5, 0, 8'h00, 5, 1, BYP ? 16'hA5A5 : 16'h0000, 16'h1234,                  8'h02, 0, 0, 1};
    tbl[10] = '{0, 8'h00, 16'h0000, 0, 8'h00, 5, 1, 16'hA5A5,                  16'h1234,                  8'h02, 0, 0, 1};
    tbl[11] = '{1, 8'h06, 16'hFFFF, 0, 8'h00, 1, 2, 16'h1234,                  16'h0C0C,                  8'h02, 1, 1, 0};
    tbl[12] = '{0, 8'h00, 16'h0000, 0, 8'h00, 1, 2, 16'h1234,                  16'h0C0C,                  8'h02, 1, 1, 0};
    tbl[13] = '{0, 8'h00, 16'h0000, 1, 8'h00, 3, 5, 16'hBEEF,                  16'hA5A5,                  8'h02, 1, 0, 0};
    tbl[14] = '{1, 8'h00, 16'h5555, 0, 8'h00, 1, 2, 16'h1234,                  16'h0C0C,                  8'h02, 1, 1, 0};

    #1;
    chk("power-on busy", busy, 0);
    chk("power-on onehot_err", onehot_err, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
      @(posedge clk); #1;
      chk($sformatf("reset read a%0d", i), rd_data_a, 0);
      chk($sformatf("reset read b%0d", 7 - i), rd_data_b, 0);
    end
    for (int i = 0; i < 15; i++) step_vec(tbl[i], i);

    // mid-operation reset with busy[1] pending and the error flag set
    reset_pulse("mid-op");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 3'(i), 3'(i));
      @(posedge clk); #1;
      chk($sformatf("post-reset read %0d", i), rd_data_a, 0);
    end
    chk("post-reset busy", busy, 0);
    chk("post-reset onehot_err", onehot_err, 0);

    for (int n = 0; n < 2000; n++) begin
      if (n % 250 == 249) reset_pulse($sformatf("rand%0d", n));
      rand_step(n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data width of each register.
REQ-002 The block SHALL have parameter NREGS, default 8, meaning the register count; it is fixed at 8 by the 8-bit one-hot selects.
REQ-003 The block SHALL have these ports, one per line as name / direction / width / meaning:
  clk  input  1  sole clock, rising edge
  rst  input  1  reset, asynchronous, active-high
  wr_en  input  1  writeback strobe
  wr_onehot  input  8  one-hot destination select, bit i selects register i
  wr_data  input  WIDTH  writeback data
  iss_valid  input  1  instruction issue strobe
  iss_onehot  input  8  one-hot destination of the issuing instruction
  rd_addr_a  input  3  read port A binary address
  rd_addr_b  input  3  read port B binary address
  rd_data_a  output  WIDTH  read port A data, registered
  rd_data_b  output  WIDTH  read port B data, registered
  busy  output  8  scoreboard, bit i set means register i has a pending write
  hazard_a  output  1  combinational: busy[rd_addr_a] and not cleared this cycle
  hazard_b  output  1  combinational: busy[rd_addr_b] and not cleared this cycle
  onehot_err  output  1  sticky illegal-select flag

Function
REQ-004 The block SHALL hold NREGS registers of WIDTH bits, all writable; no register is hardwired.
REQ-005 A select is legal only if exactly one bit is set; zero bits set or two or more bits set is illegal.
REQ-006 With wr_en=1 and a legal wr_onehot, the selected register SHALL load wr_data at the rising edge.
REQ-007 With wr_en=1 and an illegal wr_onehot, no register SHALL change, the busy vector SHALL NOT be cleared, and onehot_err SHALL set at the next edge.
REQ-008 With iss_valid=1 and a legal iss_onehot, the selected busy bit SHALL set at the next edge.
REQ-009 With iss_valid=1 and an illegal iss_onehot, busy SHALL be unchanged and onehot_err SHALL set.
REQ-010 A legal writeback SHALL clear the selected busy bit at the next edge.
REQ-011 When a legal issue and a legal writeback target the same register in the same cycle, that busy bit SHALL end set (the new producer wins), and the data write SHALL still occur.
REQ-012 Issue and writeback to different registers in the same cycle SHALL both take effect.
REQ-013 Reads SHALL have 1-cycle latency: rd_data_x at edge N+1 equals the register addressed by rd_addr_x at edge N, or the bypassed value per REQ-019.
REQ-014 hazard_x SHALL equal busy[rd_addr_x] AND NOT (wr_en AND legal wr_onehot AND wr_onehot[rd_addr_x]).
REQ-015 Once set, onehot_err SHALL remain 1 until reset.

Reset
REQ-016 Asserting rst SHALL immediately, without waiting for clk, force all registers, rd_data_a, rd_data_b, busy and onehot_err to 0; hazard_a and hazard_b consequently read 0.
REQ-017 While rst=1, writes, issues and reads SHALL be ignored; on deassertion, operation SHALL resume at the first rising edge with all state zero.
REQ-018 Reset asserted mid-operation, including between issue and writeback, SHALL discard all pending busy bits.

Configuration
REQ-019 With RF_BYPASS_EN defined, a read in the same cycle as a legal write to the same register SHALL capture wr_data into rd_data_x.
REQ-020 With RF_BYPASS_EN undefined, that same-cycle read SHALL capture the pre-write value, and the new value SHALL be visible one cycle later.
REQ-021 RF_BYPASS_EN SHALL NOT affect busy or hazard behaviour.

Verification
REQ-022 Reset then read all addresses -> every rd_data=0, busy=8'h00, onehot_err=0.
REQ-023 Write 16'hBEEF with wr_onehot=8'h08, then read rd_addr_a=3 the following cycle -> rd_data_a=16'hBEEF one cycle after the read.
REQ-024 Issue with iss_onehot=8'h04, then rd_addr_b=2 -> busy=8'h04, hazard_b=1. Then writeback to 8'h04 -> hazard_b=0 in the writeback cycle, and busy=8'h00 after the edge.
REQ-025 Same cycle: iss_onehot=8'h02 and wr_onehot=8'h02 with 16'h1234 -> busy[1]=1 and register 1 = 16'h1234.
REQ-026 wr_en with wr_onehot=8'h06 and data 16'hFFFF -> no register changes and onehot_err=1, which persists until rst.
REQ-027 Write 16'hA5A5 to register 5 while rd_addr_a=5 in the same cycle -> rd_data_a=16'hA5A5 with RF_BYPASS_EN defined; the prior value without it.
